// File: rtl/cfg_pkg.sv
// Shared types and frame constants for the config SPI bridge.
package cfg_pkg;

  localparam int unsigned FRAME_BITS = 24;
  localparam int unsigned HDR_BITS   = 8;

  // Register map of config_reg.
  typedef enum logic [2:0] {
    adc0_reg       = 3'd0,
    adc1_reg       = 3'd1,
    adc2_reg       = 3'd2,
    adc3_reg       = 3'd3,
    analog_test    = 3'd4,
    analog_config  = 3'd5,
    digital_test   = 3'd6,
    digital_config = 3'd7
  } e_reg;

  // Bridge frame FSM states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    RD_WAIT = 3'd2,
    DATA    = 3'd3,
    COMMIT  = 3'd4,
    DRAIN   = 3'd5
  } state_t;

endpackage

// File: rtl/cfg_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall pulse outputs.
module cfg_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_rise_c,
  output logic o_fall_c
);

  // r_sync[0] is the newest sample; the last two stages feed edge detection.
  logic [STAGES-1:0] r_sync;

  // Shift the pin through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_rise_c = r_sync[STAGES-2] & ~r_sync[STAGES-1];
  assign o_fall_c = ~r_sync[STAGES-2] & r_sync[STAGES-1];

endmodule

// File: rtl/cfg_spi_bridge.sv
// SPI mode-0 slave that turns 24-bit frames into config_reg write/read transactions.
module cfg_spi_bridge
  import cfg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned READ_LAT    = 1,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] data_out,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              frame_err
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS);
  localparam int unsigned LAT_W = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);

  logic w_sclk_rise, w_sclk_fall;
  logic w_cs_rise, w_cs_fall;
  logic w_mosi;

  logic [SYNC_STAGES-1:0] r_mosi_sync;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [HDR_BITS-2:0] r_hdr, w_hdr_nxt;
  logic                r_rw, w_rw_nxt;
  logic [LAT_W-1:0]    r_lat, w_lat_nxt;
  logic [DATA_W-1:0]   r_rx, w_rx_nxt;
  logic [DATA_W-1:0]   r_tx, w_tx_nxt;
  logic [ADDR_W-1:0]   r_address, w_address_nxt;
  logic [DATA_W-1:0]   r_data_in, w_data_in_nxt;
  logic                r_write, w_write_nxt;
  logic                r_miso, w_miso_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_frame_err, w_frame_err_nxt;

  cfg_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk      (clk),
    .reset    (reset),
    .i_d      (sclk),
    .o_rise_c (w_sclk_rise),
    .o_fall_c (w_sclk_fall)
  );

  cfg_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk      (clk),
    .reset    (reset),
    .i_d      (cs_n),
    .o_rise_c (w_cs_rise),
    .o_fall_c (w_cs_fall)
  );

  // mosi only needs the synchronizer path; sclk half-period leaves it settled at sampling.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_hdr       <= '0;
      r_rw        <= 1'b0;
      r_lat       <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_address   <= '0;
      r_data_in   <= '0;
      r_write     <= 1'b0;
      r_miso      <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hdr       <= w_hdr_nxt;
      r_rw        <= w_rw_nxt;
      r_lat       <= w_lat_nxt;
      r_rx        <= w_rx_nxt;
      r_tx        <= w_tx_nxt;
      r_address   <= w_address_nxt;
      r_data_in   <= w_data_in_nxt;
      r_write     <= w_write_nxt;
      r_miso      <= w_miso_nxt;
      r_busy      <= w_busy_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // Next-state and output logic for the frame FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_hdr_nxt       = r_hdr;
    w_rw_nxt        = r_rw;
    w_lat_nxt       = r_lat;
    w_rx_nxt        = r_rx;
    w_tx_nxt        = r_tx;
    w_address_nxt   = r_address;
    w_data_in_nxt   = r_data_in;
    w_write_nxt     = 1'b0;
    w_miso_nxt      = r_miso;
    w_busy_nxt      = r_busy;
    w_frame_err_nxt = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_miso_nxt = 1'b0;
        if (w_cs_fall) begin
          w_state_nxt = HDR;
          w_cnt_nxt   = '0;
          w_hdr_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end

      HDR: begin
        if (w_cs_rise) begin
          w_state_nxt     = IDLE;
          w_busy_nxt      = 1'b0;
          w_frame_err_nxt = 1'b1;
        end else if (w_sclk_rise) begin
          w_hdr_nxt = {r_hdr[HDR_BITS-3:0], w_mosi};
          w_cnt_nxt = r_cnt + CNT_W'(1);
          // Eighth bit: r_hdr already holds rw and the address field.
          if (r_cnt == CNT_W'(HDR_BITS - 1)) begin
            w_address_nxt = ADDR_W'(r_hdr[5:3]);
            w_rw_nxt      = r_hdr[6];
            if (r_hdr[6]) begin
              w_state_nxt = RD_WAIT;
              w_lat_nxt   = '0;
            end else begin
              w_state_nxt = DATA;
            end
          end
        end
      end

      RD_WAIT: begin
        if (w_cs_rise) begin
          w_state_nxt     = IDLE;
          w_busy_nxt      = 1'b0;
          w_frame_err_nxt = 1'b1;
        end else if (r_lat == LAT_W'(READ_LAT)) begin
          w_tx_nxt    = data_out;
          w_state_nxt = DATA;
        end else begin
          w_lat_nxt = r_lat + LAT_W'(1);
        end
      end

      DATA: begin
        if (w_cs_rise) begin
          w_state_nxt     = IDLE;
          w_busy_nxt      = 1'b0;
          w_frame_err_nxt = 1'b1;
          w_miso_nxt      = 1'b0;
        end else begin
          if (w_sclk_fall && r_rw) begin
            w_miso_nxt = r_tx[DATA_W-1];
            w_tx_nxt   = {r_tx[DATA_W-2:0], 1'b0};
          end
          if (w_sclk_rise) begin
            w_rx_nxt  = {r_rx[DATA_W-2:0], w_mosi};
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(FRAME_BITS - 1)) begin
              if (r_rw) begin
                w_state_nxt = DRAIN;
                w_miso_nxt  = 1'b0;
              end else begin
                w_state_nxt = COMMIT;
              end
            end
          end
        end
      end

      COMMIT: begin
        w_data_in_nxt = r_rx;
        w_write_nxt   = 1'b1;
        // A cs_n release landing on this cycle would otherwise be missed by DRAIN.
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_state_nxt = DRAIN;
        end
      end

      DRAIN: begin
        w_miso_nxt = 1'b0;
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
        w_miso_nxt  = 1'b0;
      end
    endcase
  end

  assign miso      = r_miso;
  assign write     = r_write;
  assign address   = r_address;
  assign data_in   = r_data_in;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_cfg_spi_bridge.sv
// Scoreboard bench for cfg_spi_bridge with a behavioural config_reg model.
module tb_cfg_spi_bridge;
  import cfg_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [15:0] data_out;
  logic        write;
  logic [2:0]  address;
  logic [15:0] data_in;
  logic        busy;
  logic        frame_err;

  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  wr_t         mon_e;
  int total = 0;
  int bad = 0;
  int wr_seen = 0;
  int wr_pushed = 0;
  int err_seen = 0;
  int err_exp = 0;
  logic [15:0] mem [8];

  always #5 clk = ~clk;

  cfg_spi_bridge #(
    .SYNC_STAGES (2),
    .READ_LAT    (1),
    .DATA_W      (16),
    .ADDR_W      (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .data_out  (data_out),
    .write     (write),
    .address   (address),
    .data_in   (data_in),
    .busy      (busy),
    .frame_err (frame_err)
  );

  function automatic logic [15:0] dflt(input int i);
    case (i)
      4:       return 16'habcd;
      7:       return 16'h7e57;
      default: return 16'(i * 16'h1111);
    endcase
  endfunction

  // config_reg model: registered read, one cycle latency.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mem[i] <= dflt(i);
    end else if (write) begin
      mem[address] <= data_in;
    end
    data_out <= mem[address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write-port monitor.
  always @(negedge clk) begin
    if (write) begin
      wr_seen++;
      if (reset) begin
        total++;
        bad++;
        $display("FAIL write_in_reset: got write=1 expected 0");
      end
      if (exp_wr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h expected no write", address, data_in);
      end else begin
        mon_e = exp_wr.pop_front();
        check("wr_addr", 32'(address), 32'(mon_e.a));
        check("wr_data", 32'(data_in), 32'(mon_e.d));
      end
    end
    if (frame_err) err_seen++;
  end

  // miso monitor: captures one frame at the pins and checks read data / silence.
  always begin : rd_mon
    int cnt;
    logic [23:0] sh;
    logic [15:0] rd;
    @(negedge cs_n);
    cnt = 0;
    sh = '0;
    rd = '0;
    while (cs_n === 1'b0) begin
      @(posedge sclk or posedge cs_n);
      if (cs_n === 1'b0) begin
        if (cnt < 24) begin
          sh = {sh[22:0], mosi};
          if (cnt >= 8) rd = {rd[14:0], miso};
        end
        cnt++;
      end
    end
    if (cnt >= 24) begin
      if (sh[23]) begin
        if (exp_rd.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_read: got %h expected no read", rd);
        end else begin
          check("rd_data", 32'(rd), 32'(exp_rd.pop_front()));
        end
      end else begin
        check("miso_wr_zero", 32'(rd), 32'h0);
      end
    end
  end

  task automatic chk_reset(input string tag);
    check({tag, "_write"}, 32'(write), 32'h0);
    check({tag, "_address"}, 32'(address), 32'h0);
    check({tag, "_data_in"}, 32'(data_in), 32'h0);
    check({tag, "_miso"}, 32'(miso), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
  endtask

  task automatic exp_write(input e_reg a, input logic [15:0] d);
    wr_t e;
    e.a = 3'(a);
    e.d = d;
    exp_wr.push_back(e);
    wr_pushed++;
  endtask

  function automatic logic [23:0] wframe(input e_reg a, input logic [15:0] d);
    return {1'b0, 3'(a), 4'h0, d};
  endfunction

  function automatic logic [23:0] rframe(input e_reg a);
    return {1'b1, 3'(a), 4'ha, 16'h0};
  endfunction

  // Drive one frame; nbits < 24 aborts, rst_at >= 0 pulses reset before that bit.
  task automatic send(input logic [23:0] f, input int nbits, input int rst_at, input int gap);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 24) ? f[23-i] : 1'b1;
      if (i == rst_at) begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("midrst");
        reset = 1'b0;
        repeat (2) @(negedge clk);
      end
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
      if (i == 4) check("busy_mid", 32'(busy), 32'h1);
    end
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (gap) @(negedge clk);
    check("busy_end", 32'(busy), 32'h0);
  endtask

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (4) @(negedge clk);
    chk_reset("rst");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Write then read back adc1_reg.
    exp_write(adc1_reg, 16'h4acc);
    send(wframe(adc1_reg, 16'h4acc), 24, -1, 4);
    exp_rd.push_back(16'h4acc);
    send(rframe(adc1_reg), 24, -1, 4);

    // Fresh reset, read analog_test default.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    exp_rd.push_back(16'habcd);
    send(rframe(analog_test), 24, -1, 4);

    // Back-to-back writes with minimum cs_n gap.
    exp_write(adc0_reg, 16'h11bc);
    send(wframe(adc0_reg, 16'h11bc), 24, -1, 2);
    exp_write(analog_config, 16'h980d);
    send(wframe(analog_config, 16'h980d), 24, -1, 2);
    exp_write(digital_test, 16'h34f3);
    send(wframe(digital_test, 16'h34f3), 24, -1, 2);
    exp_rd.push_back(16'h980d);
    send(rframe(analog_config), 24, -1, 4);

    // Abort after 12 bits; target keeps its prior value.
    err_exp++;
    send(wframe(digital_config, 16'h9100), 12, -1, 4);
    check("data_in_hold", 32'(data_in), 32'h34f3);
    exp_rd.push_back(16'h7e57);
    send(rframe(digital_config), 24, -1, 4);

    // Reset mid-DATA with cs_n held low; then a normal frame.
    send(wframe(analog_config, 16'hdead), 24, 14, 4);
    exp_write(adc3_reg, 16'h5a5a);
    send(wframe(adc3_reg, 16'h5a5a), 24, -1, 4);

    // 30 clocks in one frame; extras ignored.
    exp_write(adc2_reg, 16'hf1a0);
    send(wframe(adc2_reg, 16'hf1a0), 30, -1, 4);
    exp_rd.push_back(16'hf1a0);
    send(rframe(adc2_reg), 24, -1, 4);

    repeat (20) @(negedge clk);
    check("wr_count", 32'(wr_seen), 32'(wr_pushed));
    check("wr_queue_left", 32'(exp_wr.size()), 32'h0);
    check("rd_queue_left", 32'(exp_rd.size()), 32'h0);
    check("err_count", 32'(err_seen), 32'(err_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
